// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control blocks: operand-mux
// encodings, the memory-wait FSM state type and default widths.
package cpu_pkg;

   // Default register-address width (32 architectural registers)
   localparam int REG_AW_DEF = 5;

   // Operand mux encoding used by the EX-stage forwarding muxes
   localparam logic [1:0] FWD_REG   = 2'b00;   // value read from the register file
   localparam logic [1:0] FWD_EXMEM = 2'b01;   // result held in EX/MEM
   localparam logic [1:0] FWD_MEMWB = 2'b10;   // result held in MEM/WB

   // Pipeline-level state: free running, or stalled on data memory
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } fsm_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forward-select generator for one ALU operand. Purely combinational:
// compares the operand's source register against the EX/MEM and MEM/WB
// destinations and picks the youngest matching producer. Register 0 is
// hard-wired to zero and therefore never forwarded.
module fwd_select
   import cpu_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              exmem_valid,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              memwb_valid,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [REG_AW-1:0] src_reg,
   output logic [1:0]        sel
);

   logic exmem_hit_s;
   logic memwb_hit_s;

   // A slot can forward only if it holds a live instruction writing a non-zero register
   always_comb begin
      exmem_hit_s = exmem_valid && exmem_reg_write &&
                    (exmem_rd != {REG_AW{1'b0}}) && (exmem_rd == src_reg);
      memwb_hit_s = memwb_valid && memwb_reg_write &&
                    (memwb_rd != {REG_AW{1'b0}}) && (memwb_rd == src_reg);
   end

   // EX/MEM holds the younger result, so it wins over MEM/WB
   always_comb begin
      sel = FWD_REG;
      if (exmem_hit_s) begin
         sel = FWD_EXMEM;
      end else if (memwb_hit_s) begin
         sel = FWD_MEMWB;
      end else begin
         sel = FWD_REG;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// Shadows the destination/control fields of ID/EX, EX/MEM and MEM/WB,
// drives the EX operand forward selects, detects load-use hazards,
// applies branch flushes and freezes the whole pipeline while data
// memory is busy. Stall and flush events are counted with saturation.
module fwd_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              ex_branch_taken,
   input  logic              mem_busy,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              freeze,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

   // ID/EX shadow slot
   logic              idex_valid_r;
   logic [REG_AW-1:0] idex_rs1_r;
   logic [REG_AW-1:0] idex_rs2_r;
   logic [REG_AW-1:0] idex_rd_r;
   logic              idex_reg_write_r;
   logic              idex_mem_read_r;

   // EX/MEM shadow slot
   logic              exmem_valid_r;
   logic [REG_AW-1:0] exmem_rd_r;
   logic              exmem_reg_write_r;

   // MEM/WB shadow slot
   logic              memwb_valid_r;
   logic [REG_AW-1:0] memwb_rd_r;
   logic              memwb_reg_write_r;

   // Memory-wait FSM
   fsm_state_t state_r;
   fsm_state_t state_nxt_s;

   // Hazard decode
   logic hold_s;
   logic load_use_s;
   logic stall_inc_s;
   logic flush_inc_s;

   // Saturating counters
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // One forward-select generator per ALU operand
   fwd_select #(
      .REG_AW          (REG_AW)
   ) u_fwd_a (
      .exmem_valid     (exmem_valid_r),
      .exmem_reg_write (exmem_reg_write_r),
      .exmem_rd        (exmem_rd_r),
      .memwb_valid     (memwb_valid_r),
      .memwb_reg_write (memwb_reg_write_r),
      .memwb_rd        (memwb_rd_r),
      .src_reg         (idex_rs1_r),
      .sel             (forward_a)
   );

   fwd_select #(
      .REG_AW          (REG_AW)
   ) u_fwd_b (
      .exmem_valid     (exmem_valid_r),
      .exmem_reg_write (exmem_reg_write_r),
      .exmem_rd        (exmem_rd_r),
      .memwb_valid     (memwb_valid_r),
      .memwb_reg_write (memwb_reg_write_r),
      .memwb_rd        (memwb_rd_r),
      .src_reg         (idex_rs2_r),
      .sel             (forward_b)
   );

   // Freeze condition and load-use detection against the decoding instruction
   always_comb begin
      hold_s     = (state_r == MEM_WAIT) || mem_busy;
      load_use_s = idex_valid_r && idex_mem_read_r && (idex_rd_r != REG_ZERO) &&
                   id_valid && ((idex_rd_r == id_rs1) || (idex_rd_r == id_rs2));
   end

   // FSM next state: enter MEM_WAIT on busy, leave on the first non-busy cycle
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (mem_busy) begin
               state_nxt_s = MEM_WAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               state_nxt_s = MEM_WAIT;
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // Pipeline control outputs; priority is freeze, then branch flush, then load-use
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      freeze      = 1'b0;
      stall_inc_s = 1'b0;
      flush_inc_s = 1'b0;
      if (hold_s) begin
         freeze     = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_inc_s = 1'b1;
      end else if (load_use_s) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall_inc_s = 1'b1;
      end else begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Shadow slots advance with the pipeline unless frozen; bubbles carry zeroed fields
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idex_valid_r      <= 1'b0;
         idex_rs1_r        <= REG_ZERO;
         idex_rs2_r        <= REG_ZERO;
         idex_rd_r         <= REG_ZERO;
         idex_reg_write_r  <= 1'b0;
         idex_mem_read_r   <= 1'b0;
         exmem_valid_r     <= 1'b0;
         exmem_rd_r        <= REG_ZERO;
         exmem_reg_write_r <= 1'b0;
         memwb_valid_r     <= 1'b0;
         memwb_rd_r        <= REG_ZERO;
         memwb_reg_write_r <= 1'b0;
      end else if (!freeze) begin
         memwb_valid_r     <= exmem_valid_r;
         memwb_rd_r        <= exmem_rd_r;
         memwb_reg_write_r <= exmem_reg_write_r;
         exmem_valid_r     <= idex_valid_r;
         exmem_rd_r        <= idex_rd_r;
         exmem_reg_write_r <= idex_reg_write_r;
         if (idex_bubble || !id_valid) begin
            idex_valid_r     <= 1'b0;
            idex_rs1_r       <= REG_ZERO;
            idex_rs2_r       <= REG_ZERO;
            idex_rd_r        <= REG_ZERO;
            idex_reg_write_r <= 1'b0;
            idex_mem_read_r  <= 1'b0;
         end else begin
            idex_valid_r     <= 1'b1;
            idex_rs1_r       <= id_rs1;
            idex_rs2_r       <= id_rs2;
            idex_rd_r        <= id_rd;
            idex_reg_write_r <= id_reg_write;
            idex_mem_read_r  <= id_mem_read;
         end
      end else begin
         memwb_valid_r     <= memwb_valid_r;
         memwb_rd_r        <= memwb_rd_r;
         memwb_reg_write_r <= memwb_reg_write_r;
         exmem_valid_r     <= exmem_valid_r;
         exmem_rd_r        <= exmem_rd_r;
         exmem_reg_write_r <= exmem_reg_write_r;
         idex_valid_r      <= idex_valid_r;
         idex_rs1_r        <= idex_rs1_r;
         idex_rs2_r        <= idex_rs2_r;
         idex_rd_r         <= idex_rd_r;
         idex_reg_write_r  <= idex_reg_write_r;
         idex_mem_read_r   <= idex_mem_read_r;
      end
   end

   // Stall counter: counts accepted load-use stalls, sticks at all ones
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt_r <= CNT_ZERO;
      end else if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Flush counter: counts accepted branch flushes, sticks at all ones
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flush_cnt_r <= CNT_ZERO;
      end else if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
         flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
         flush_cnt_r <= flush_cnt_r;
      end
   end

   // Counter outputs come straight from their registers
   always_comb begin
      stall_cnt = stall_cnt_r;
      flush_cnt = flush_cnt_r;
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl. The driver applies one directed
// vector per cycle and queues the hand-computed response; the monitor
// pops one entry per cycle on the falling edge and compares.
module tb_fwd_hazard_ctrl;

   localparam int TB_CNT_W = 4;

   typedef struct packed {
      logic [7:0]          step;
      logic                chk_fwd;
      logic                chk_ctrl;
      logic [1:0]          fa;
      logic [1:0]          fb;
      logic                pw;
      logic                iw;
      logic                bub;
      logic                fl;
      logic                fz;
      logic [TB_CNT_W-1:0] sc;
      logic [TB_CNT_W-1:0] fc;
   } exp_t;

   logic                clk;
   logic                reset_n;
   logic                id_valid;
   logic [4:0]          id_rs1;
   logic [4:0]          id_rs2;
   logic [4:0]          id_rd;
   logic                id_reg_write;
   logic                id_mem_read;
   logic                ex_branch_taken;
   logic                mem_busy;
   logic [1:0]          forward_a;
   logic [1:0]          forward_b;
   logic                pc_write;
   logic                ifid_write;
   logic                idex_bubble;
   logic                ifid_flush;
   logic                freeze;
   logic [TB_CNT_W-1:0] stall_cnt;
   logic [TB_CNT_W-1:0] flush_cnt;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests;
   int   n_fail;
   int   step_no;

   fwd_hazard_ctrl #(
      .REG_AW          (5),
      .CNT_W           (TB_CNT_W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rd           (id_rd),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .forward_a       (forward_a),
      .forward_b       (forward_b),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .idex_bubble     (idex_bubble),
      .ifid_flush      (ifid_flush),
      .freeze          (freeze),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input int st, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL step %0d %s: got %0d, expected %0d", st, nm, got, want);
      end
   endtask

   // Monitor: one queued expectation per cycle, sampled away from the clock edge
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.chk_fwd) begin
            cmp("forward_a", int'(mon_e.step), int'(forward_a), int'(mon_e.fa));
            cmp("forward_b", int'(mon_e.step), int'(forward_b), int'(mon_e.fb));
         end
         if (mon_e.chk_ctrl) begin
            cmp("pc_write",    int'(mon_e.step), int'(pc_write),    int'(mon_e.pw));
            cmp("ifid_write",  int'(mon_e.step), int'(ifid_write),  int'(mon_e.iw));
            cmp("idex_bubble", int'(mon_e.step), int'(idex_bubble), int'(mon_e.bub));
            cmp("ifid_flush",  int'(mon_e.step), int'(ifid_flush),  int'(mon_e.fl));
            cmp("freeze",      int'(mon_e.step), int'(freeze),      int'(mon_e.fz));
         end
         cmp("stall_cnt", int'(mon_e.step), int'(stall_cnt), int'(mon_e.sc));
         cmp("flush_cnt", int'(mon_e.step), int'(flush_cnt), int'(mon_e.fc));
      end
   end

   // Apply one cycle of inputs just after the rising edge
   task automatic step_in(input logic rst, input logic v,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic br, input logic busy);
      @(posedge clk);
      #1;
      reset_n         = rst;
      id_valid        = v;
      id_rs1          = rs1;
      id_rs2          = rs2;
      id_rd           = rd;
      id_reg_write    = rw;
      id_mem_read     = mr;
      ex_branch_taken = br;
      mem_busy        = busy;
   endtask

   // Queue the expected response for the cycle just driven
   task automatic exp(input logic cf, input logic cc, input logic [1:0] fa, input logic [1:0] fb,
                      input logic pw, input logic iw, input logic bub, input logic fl,
                      input logic fz, input int sc, input int fc);
      exp_t e;
      e.step     = step_no[7:0];
      e.chk_fwd  = cf;
      e.chk_ctrl = cc;
      e.fa       = fa;
      e.fb       = fb;
      e.pw       = pw;
      e.iw       = iw;
      e.bub      = bub;
      e.fl       = fl;
      e.fz       = fz;
      e.sc       = sc[TB_CNT_W-1:0];
      e.fc       = fc[TB_CNT_W-1:0];
      sb_q.push_back(e);
      step_no++;
   endtask

   // Normal running cycle with given forward selects, no hazard
   task automatic exp_fwd(input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
      exp(1'b1, 1'b1, fa, fb, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sc, fc);
   endtask

   // Idle/default cycle
   task automatic exp_def(input int sc, input int fc);
      exp_fwd(2'b00, 2'b00, sc, fc);
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      step_no         = 0;
      reset_n         = 1'b0;
      id_valid        = 1'b0;
      id_rs1          = 5'd0;
      id_rs2          = 5'd0;
      id_rd           = 5'd0;
      id_reg_write    = 1'b0;
      id_mem_read     = 1'b0;
      ex_branch_taken = 1'b0;
      mem_busy        = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      // EX/MEM beats MEM/WB when both write x3
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_fwd(2'b01, 2'b00, 0, 0);
      // EX/MEM writes x4, MEM/WB writes x3: A from MEM/WB, B from EX/MEM
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_fwd(2'b10, 2'b01, 0, 0);
      // x0 writer in EX/MEM never forwarded
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      // Load x5 followed by a user of x5 on rs2
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); exp_def(0, 0);
      step_in(1'b1, 1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      exp(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      step_in(1'b1, 1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(1, 0);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_fwd(2'b00, 2'b10, 1, 0);
      // Load-use coinciding with a taken branch: flush wins
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0); exp_def(1, 0);
      step_in(1'b1, 1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      exp(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(1, 1);
      // Memory wait with EX/MEM forwarding active on both operands
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(1, 1);
      step_in(1'b1, 1'b1, 5'd10, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp(1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      exp(1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
      exp(1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp(1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(1, 1);
      // Reset while in MEM_WAIT
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(1, 1);
      step_in(1'b1, 1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0); exp_def(1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
      step_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 0);
      // Flush counter saturation with a narrow counter
      for (int i = 0; i < 18; i++) begin
         step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         exp(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, (i > 15) ? 15 : i);
      end
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 15);
      // Invalid decode never stalls; rs1 match does
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); exp_def(0, 15);
      step_in(1'b1, 1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(0, 15);
      step_in(1'b1, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); exp_def(0, 15);
      step_in(1'b1, 1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      exp(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 15);
      step_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exp_def(1, 15);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10; i++) begin
         if (sb_q.size() > 0) begin
            @(negedge clk);
         end
      end
      #2;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
